kmap_tt_scanner: RTL

- Sequential stimulus/capture stage for the combinational K-map function blocks (2, 3 or 4 inputs, single output F).
- On a start pulse it walks every input combination in ascending minterm order and drives it onto the function's inputs.
- After a settle interval it samples F and assembles the captured truth table as a minterm mask.
- It compares the mask against an expected mask and reports pass/fail, mismatch count and the first failing minterm.

---
 rtl/kmap_pkg.sv | 11 +
 rtl/kmap_settle_timer.sv | 24 ++
 rtl/kmap_tt_scanner.sv | 94 +++++++++
 3 files changed

// File: rtl/kmap_pkg.sv
// Shared types and sizing for the K-map truth-table scanner.
package kmap_pkg;
  localparam int MAX_VARS = 4;
  localparam int TT_W     = 16;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} kmap_scan_state_t;

  function automatic int num_minterms(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/kmap_settle_timer.sv
// Loadable down-counter; expire is high once the loaded settle interval has elapsed.
module kmap_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);
  localparam int W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  // Loaded with N-1 so that expire marks the last of N settle cycles.
  localparam logic [W-1:0] LOAD_V = W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= LOAD_V;
    else if (count && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);
endmodule

// File: rtl/kmap_tt_scanner.sv
// Walks all minterms of an N_VARS-input function, captures F, and checks it against an expected mask.
module kmap_tt_scanner
  import kmap_pkg::*;
#(
  parameter int N_VARS        = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected_tt,
  output logic [3:0]  vec_out,
  input  logic        f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_out,
  output logic        pass,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail_idx,
  output logic        first_fail_valid
);
  localparam logic [3:0] LAST_IDX = 4'(num_minterms(N_VARS) - 1);
  localparam kmap_scan_state_t STEP_ST = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;

  kmap_scan_state_t state;
  logic [3:0]  idx;
  logic [15:0] exp_q;
  logic        mis;
  logic [4:0]  mm_next;
  logic        expire;
  logic        tmr_load;

  assign mis      = f_in ^ exp_q[idx];
  assign mm_next  = mismatch_cnt + {4'd0, mis};
  assign tmr_load = (SETTLE_CYCLES > 0) &&
                    ((state == IDLE && start) || (state == SAMPLE && idx != LAST_IDX));

  assign busy    = (state == SETTLE) || (state == SAMPLE);
  assign done    = (state == DONE);
  assign vec_out = busy ? idx : 4'd0;

  kmap_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .count  (state == SETTLE),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= 4'd0;
      exp_q            <= 16'd0;
      tt_out           <= 16'd0;
      mismatch_cnt     <= 5'd0;
      first_fail_idx   <= 4'd0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          exp_q            <= expected_tt;
          idx              <= 4'd0;
          tt_out           <= 16'd0;
          mismatch_cnt     <= 5'd0;
          first_fail_idx   <= 4'd0;
          first_fail_valid <= 1'b0;
          pass             <= 1'b0;
          state            <= STEP_ST;
        end
        SETTLE: if (expire) state <= SAMPLE;
        SAMPLE: begin
          tt_out[idx]  <= f_in;
          mismatch_cnt <= mm_next;
          if (mis && !first_fail_valid) begin
            first_fail_idx   <= idx;
            first_fail_valid <= 1'b1;
          end
          // pass is resolved here so it is already valid in the DONE cycle
          if (idx == LAST_IDX) begin
            pass  <= (mm_next == 5'd0);
            state <= DONE;
          end else begin
            idx   <= idx + 4'd1;
            state <= STEP_ST;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
